// File: rtl/fb_wr_arbiter.sv
// Framebuffer write arbiter: grants one client at a time for up to MAX_RUN beats
// and forwards its writes through a single registered output stage.
module fb_wr_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_RUN    = 16,
  parameter int PRIO_MODE  = 0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_CH-1:0]                s_wr_valid,
  output logic [NUM_CH-1:0]                s_wr_ready,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     s_wr_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     s_wr_data,
  output logic                             m_wr_valid,
  input  logic                             m_wr_ready,
  output logic [ADDR_WIDTH-1:0]            m_wr_addr,
  output logic [DATA_WIDTH-1:0]            m_wr_data,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] m_wr_ch,
  output logic                             busy
);

  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RUNW = $clog2(MAX_RUN + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CHW-1:0]        g_q, g_d, rr_q, rr_d, sel, g_next;
  logic [RUNW-1:0]       run_q, run_d, run_inc;
  logic                  armed_q;
  logic                  m_valid_q, m_valid_d;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [CHW-1:0]        m_ch_q;
  logic                  g_valid, found, out_free, accept, release_g;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;

  // First pass covers channels at/after rr (all of them in fixed mode); second pass wraps.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && s_wr_valid[c] && (PRIO_MODE != 0 || CHW'(c) >= rr_q)) begin
        sel   = CHW'(c);
        found = 1'b1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && s_wr_valid[c]) begin
        sel   = CHW'(c);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid    = 1'b0;
    g_addr     = '0;
    g_data     = '0;
    s_wr_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (g_q == CHW'(c)) begin
        g_valid       = s_wr_valid[c];
        g_addr        = s_wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        g_data        = s_wr_data[c*DATA_WIDTH +: DATA_WIDTH];
        s_wr_ready[c] = (state_q == S_GRANT) && out_free;
      end
    end
  end

  assign out_free  = !m_valid_q || m_wr_ready;
  assign accept    = (state_q == S_GRANT) && g_valid && out_free;
  assign g_next    = (g_q == CHW'(NUM_CH - 1)) ? '0 : g_q + CHW'(1);
  assign run_inc   = run_q + RUNW'(1);
  assign m_valid_d = accept || (m_valid_q && !m_wr_ready);

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_d      = rr_q;
    run_d     = run_q;
    release_g = 1'b0;
    if (state_q == S_IDLE) begin
      if (armed_q && (|s_wr_valid)) begin
        g_d     = sel;
        run_d   = '0;
        state_d = S_GRANT;
      end
    end else if (accept) begin
      run_d     = run_inc;
      release_g = (run_inc == RUNW'(MAX_RUN));
    end else begin
      release_g = !g_valid;
    end
    if (release_g) begin
      state_d = S_IDLE;
      rr_d    = g_next;
    end
  end

  // armed_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      run_q     <= '0;
      armed_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      run_q     <= run_d;
      armed_q   <= 1'b1;
      m_valid_q <= m_valid_d;
      if (accept) begin
        m_addr_q <= g_addr;
        m_data_q <= g_data;
        m_ch_q   <= g_q;
      end
    end
  end

  assign m_wr_valid = m_valid_q;
  assign m_wr_addr  = m_addr_q;
  assign m_wr_data  = m_data_q;
  assign m_wr_ch    = m_ch_q;
  assign busy       = (state_q == S_GRANT) || m_valid_q;

endmodule
